// File: rtl/approx_mul_pkg.sv
// Shared types for the approximate multiplier: per-quadrant mode encoding
// and the packed {hh, hl, lh, ll} mode word carried alongside each operand pair.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'd0,
    MODE_TRUNC0 = 2'd1,
    MODE_TRUNC1 = 2'd2,
    MODE_LSBZ   = 2'd3
  } mode_t;

  // Field order matches the cfg_mode byte: hh in [7:6] down to ll in [1:0].
  typedef struct packed {
    mode_t hh;
    mode_t hl;
    mode_t lh;
    mode_t ll;
  } quad_mode_t;

  localparam int unsigned QUAD_MODE_BITS = $bits(quad_mode_t);

  // Reinterpret a raw configuration byte as a quadrant mode word.
  function automatic quad_mode_t to_quad_mode(input logic [QUAD_MODE_BITS-1:0] raw);
    return quad_mode_t'(raw);
  endfunction

endpackage

// File: rtl/approx_quad_mul.sv
// Combinational H x H unsigned quadrant multiplier with a run-time approximation mode.
module approx_quad_mul
  import approx_mul_pkg::*;
#(
  parameter int unsigned H     = 4,
  parameter int unsigned TRUNC = 2
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  mode_t          mode,
  output logic [2*H-1:0] p
);

  localparam int unsigned PW = 2 * H;
  // Ones in the TRUNC least-significant product bits.
  localparam logic [PW-1:0] TMASK = {PW{1'b1}} >> (PW - TRUNC);

  logic [H-1:0]  a_m;
  logic [H-1:0]  b_m;
  logic [PW-1:0] exact;

  // Operand conditioning, full-width product, then LSB forcing by mode.
  always_comb begin
    a_m = a;
    b_m = b;
    if (mode == MODE_LSBZ) begin
      a_m[0] = 1'b0;
      b_m[0] = 1'b0;
    end
    exact = {{H{1'b0}}, a_m} * {{H{1'b0}}, b_m};
    case (mode)
      MODE_TRUNC0: p = exact & ~TMASK;
      MODE_TRUNC1: p = exact | TMASK;
      default:     p = exact;
    endcase
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined approximate unsigned multiplier with a valid/ready
// stream interface and a per-quadrant run-time mode register.
//   S1: operands + sampled mode   S2: four quadrant products   S3: final sum
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TRUNC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  input  logic [7:0]           cfg_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 busy
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned QW = 2 * H;
  localparam int unsigned PW = 2 * WIDTH;

  quad_mode_t mode_q;

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  quad_mode_t       s1_mode;

  logic          s2_v;
  logic [QW-1:0] s2_hh;
  logic [QW-1:0] s2_hl;
  logic [QW-1:0] s2_lh;
  logic [QW-1:0] s2_ll;

  logic          s3_v;
  logic [PW-1:0] s3_prod;

  logic          s1_en;
  logic          s2_en;
  logic          s3_en;

  logic [QW-1:0] q_hh;
  logic [QW-1:0] q_hl;
  logic [QW-1:0] q_lh;
  logic [QW-1:0] q_ll;
  logic [PW-1:0] sum;

  // Stage load enables: a stage may load when empty or when its content
  // leaves on the same edge, so bubbles collapse and in_ready ripples back
  // combinationally from out_ready.
  always_comb begin
    s3_en    = !s3_v || out_ready;
    s2_en    = !s2_v || s3_en;
    s1_en    = !s1_v || s2_en;
    in_ready = s1_en;
  end

  // Mode register; a pair accepted on the load edge still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
    end else if (cfg_load) begin
      mode_q <= to_quad_mode(cfg_mode);
    end
  end

  // S1: capture operands together with the mode in force at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= mode_q;
      end
    end
  end

  // Quadrant products; HL is A_high x B_low, LH is A_low x B_high.
  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_hh (
    .a    (s1_a[WIDTH-1:H]),
    .b    (s1_b[WIDTH-1:H]),
    .mode (s1_mode.hh),
    .p    (q_hh)
  );

  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_hl (
    .a    (s1_a[WIDTH-1:H]),
    .b    (s1_b[H-1:0]),
    .mode (s1_mode.hl),
    .p    (q_hl)
  );

  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_lh (
    .a    (s1_a[H-1:0]),
    .b    (s1_b[WIDTH-1:H]),
    .mode (s1_mode.lh),
    .p    (q_lh)
  );

  approx_quad_mul #(.H(H), .TRUNC(TRUNC)) u_ll (
    .a    (s1_a[H-1:0]),
    .b    (s1_b[H-1:0]),
    .mode (s1_mode.ll),
    .p    (q_ll)
  );

  // S2: register the four quadrant products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_hh <= '0;
      s2_hl <= '0;
      s2_lh <= '0;
      s2_ll <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_hh <= q_hh;
        s2_hl <= q_hl;
        s2_lh <= q_lh;
        s2_ll <= q_ll;
      end
    end
  end

  // Adder tree. Forced-one LSBs can push the true sum past 2*WIDTH bits;
  // the result is defined modulo 2^(2*WIDTH), so the carry out is never formed.
  always_comb begin
    sum = (PW'(s2_hh) << WIDTH)
        + ((PW'(s2_hl) + PW'(s2_lh)) << H)
        + PW'(s2_ll);
  end

  // S3: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v    <= 1'b0;
      s3_prod <= '0;
    end else if (s3_en) begin
      s3_v <= s2_v;
      if (s2_v) begin
        s3_prod <= sum;
      end
    end
  end

  // Output and occupancy status.
  always_comb begin
    out_valid = s3_v;
    out_prod  = s3_prod;
    busy      = s1_v || s2_v || s3_v;
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (WIDTH=8, TRUNC=2): a behavioural
// arithmetic model feeds an expected-result queue, a negedge monitor checks
// every output transfer and stall hold, and directed tests pin literal values.
module tb_approx_mul_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int unsigned T = 2;

  logic           clk;
  logic           rst_n;
  logic           cfg_load;
  logic [7:0]     cfg_mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  int unsigned pass_cnt;
  int unsigned total_cnt;
  int unsigned cyc;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] outs[$];
  logic [7:0]     mode_m;
  bit             held;
  logic [2*W-1:0] held_val;

  approx_mul_pipe #(.WIDTH(W), .TRUNC(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Quadrant value from the mode rules, plain arithmetic.
  function automatic int unsigned quad(input int unsigned x, input int unsigned y, input int unsigned m);
    int unsigned p;
    if (m == 3) p = ((x / 2) * 2) * ((y / 2) * 2);
    else        p = x * y;
    if (m == 1)      p = p - (p % (1 << T));
    else if (m == 2) p = p - (p % (1 << T)) + ((1 << T) - 1);
    return p;
  endfunction

  function automatic logic [2*W-1:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int unsigned ah, al, bh, bl, s;
    ah = int'(a) / (1 << H);  al = int'(a) % (1 << H);
    bh = int'(b) / (1 << H);  bl = int'(b) % (1 << H);
    s = quad(ah, bh, (int'(m) / 64) % 4) * (1 << W)
      + (quad(ah, bl, (int'(m) / 16) % 4) + quad(al, bh, (int'(m) / 4) % 4)) * (1 << H)
      + quad(al, bl, int'(m) % 4);
    return (2*W)'(s % (1 << (2*W)));
  endfunction

  // Monitor: every output transfer against the model queue, stall hold,
  // and model bookkeeping for accepted pairs and mode loads.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mode_m = 8'h00;
      held   = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_prod", out_prod, held_val);
      end
      if (out_valid) begin
        if (out_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) check("unexpected_output", out_prod, 0);
          else check("stream_prod", out_prod, exp_q.pop_front());
          outs.push_back(out_prod);
        end else begin
          held     = 1'b1;
          held_val = out_prod;
        end
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, mode_m));
      if (cfg_load) mode_m = cfg_mode;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair; returns one time unit after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic cfg(input logic [7:0] m);
    cfg_load = 1'b1;
    cfg_mode = m;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) check("drain_timeout", 1, 0);
  endtask

  // Single transaction into an empty pipe: check latency and literal result.
  task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [2*W-1:0] expv);
    int lat;
    out_ready = 1'b1;
    send(a, b);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check(name, out_prod, expv);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, n0;
    int unsigned c0;
    bit done;
    logic [7:0] pa[5];
    logic [7:0] pb[5];

    pass_cnt = 0; total_cnt = 0; cyc = 0;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = 8'h00;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // Model pins from hand-computed values.
    check("pin_200x100", model(8'd200, 8'd100, 8'h00), 20000);
    check("pin_255x255", model(8'd255, 8'd255, 8'h00), 65025);
    check("pin_ll_trunc0", model(8'h0F, 8'h0F, 8'h01), 224);
    check("pin_ll_trunc1", model(8'h0F, 8'h0F, 8'h02), 227);
    check("pin_ll_lsbz", model(8'h0F, 8'h0F, 8'h03), 196);
    check("pin_hh_trunc0", model(8'h40, 8'h40, 8'h40), 4096);
    check("pin_all_trunc1_wrap", model(8'd255, 8'd255, 8'hAA), 67);

    // Reset state.
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prod", out_prod, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Directed products and mode behaviour.
    run_one("exact_200x100", 8'd200, 8'd100, 20000);
    run_one("exact_255x255", 8'd255, 8'd255, 65025);
    cfg(8'h01); run_one("ll_trunc0", 8'h0F, 8'h0F, 224);
    cfg(8'h02); run_one("ll_trunc1", 8'h0F, 8'h0F, 227);
    cfg(8'h03); run_one("ll_lsbz", 8'h0F, 8'h0F, 196);
    cfg(8'h40); run_one("hh_trunc0", 8'h40, 8'h40, 4096);
    cfg(8'hAA); run_one("trunc1_wrap", 8'd255, 8'd255, 67);
    cfg(8'h00);

    // Back-to-back random stream, unstalled.
    out_ready = 1'b1;
    n0 = outs.size();
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check("stream_accept_cycles", cyc - c0, 16);
    drain(n);
    check("stream_drain_cycles", n, 3);
    check("stream_count", outs.size() - n0, 16);

    // Backpressure: capacity three, output held, all five emerge in order.
    for (int i = 0; i < 5; i++) begin
      pa[i] = 8'(17 * i + 3);
      pb[i] = 8'(29 * i + 11);
    end
    out_ready = 1'b0;
    n0 = outs.size();
    for (int i = 0; i < 3; i++) send(pa[i], pb[i]);
    in_valid = 1'b1; in_a = pa[3]; in_b = pb[3];
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_prod_first", out_prod, model(pa[0], pb[0], 8'h00));
    repeat (3) tick();
    check("bp_in_ready_still", in_ready, 0);
    check("bp_out_prod_held", out_prod, model(pa[0], pb[0], 8'h00));
    check("bp_busy", busy, 1);
    out_ready = 1'b1;
    send(pa[3], pb[3]);
    send(pa[4], pb[4]);
    drain(n);
    check("bp_count", outs.size() - n0, 5);
    for (int i = 0; i < 5; i++)
      if (n0 + i < outs.size()) check("bp_order", outs[n0 + i], model(pa[i], pb[i], 8'h00));

    // Mode change with items in flight; pair on the load edge keeps old mode.
    n0 = outs.size();
    send(8'd200, 8'd100);
    send(8'd255, 8'd255);
    cfg_load = 1'b1; cfg_mode = 8'hFF;
    send(8'h0F, 8'h0F);
    cfg_load = 1'b0;
    send(8'h0F, 8'h0F);
    drain(n);
    check("cfg_count", outs.size() - n0, 4);
    if (outs.size() >= n0 + 4) begin
      check("cfg_inflight0", outs[n0], 20000);
      check("cfg_inflight1", outs[n0 + 1], 65025);
      check("cfg_same_edge_old", outs[n0 + 2], 225);
      check("cfg_new_mode", outs[n0 + 3], 196);
    end

    // Reset mid-operation discards in-flight items and clears the mode.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i + 40), 8'(i + 90));
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    n0 = outs.size();
    run_one("after_rst_exact", 8'h0F, 8'h0F, 225);
    run_one("after_rst_200x100", 8'd200, 8'd100, 20000);
    check("after_rst_count", outs.size() - n0, 2);

    // Random stream with random stalls and occasional mode reloads.
    n0 = outs.size();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if (i % 10 == 5) begin
            cfg_load = 1'b1;
            cfg_mode = 8'($urandom_range(0, 255));
          end
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          cfg_load = 1'b0;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain(n);
    check("rand_count", outs.size() - n0, 40);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
